result_display: RTL and testbench
=================================

# result_display

Downstream consumer of the shift-add multiplier's 16-bit `AQ` product. On each rising edge of the multiplier's `READY`, the block captures `AQ` and converts it to five BCD digits with a sequential double-dabble converter. It then drives a 5-digit, common-anode, time-multiplexed seven-segment display. It runs on the same clock as the multiplier and needs no handshake back to it.

## Interface
Parameters:
- `REFRESH_DIV`, default 3330: clock cycles each digit stays lit (about 1 ms at 3.33 MHz).
- `BLANK_LEADING`, default 1: when 1, leading-zero digits above the units digit are blanked.

Ports:
- `clk`, input, 1: single system clock; all state changes on its rising edge.
- `n_reset`, input, 1: asynchronous, active-low reset.
- `AQ`, input, 16: product from the multiplier; stable while `READY` is high.
- `READY`, input, 1: multiplier done flag; a rising edge requests a conversion.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- `an`, output, 5: digit enables, active-low; `an[0]` is the units digit.
- `busy`, output, 1: high while a conversion is in progress.

## Operation
- Edge detect: `ready_q` is a registered copy of `READY`. A request is `READY & ~ready_q`.
- FSM states are IDLE, SHIFT and LATCH.
  - IDLE: on a request, load `AQ` into the 16-bit binary register, clear the 20-bit BCD register, set iteration count to 0, go to SHIFT.
  - SHIFT: in each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd, bin} left by 1. The count increments each cycle. After iteration 15 (the 16th), go to LATCH.
  - LATCH: copy the BCD register into the five display digit registers. If `pending` is set, clear it, reload from `AQ` and go to SHIFT. Otherwise go to IDLE.
- A request that arrives in SHIFT or LATCH sets the one-deep `pending` flag. Further requests while `pending` is set are merged into it. The value converted is `AQ` as sampled at reload.
- The result range is 0 to 65535. The top digit never exceeds 6 and no BCD overflow is possible.
- Scan:
  - The refresh counter runs from 0 to `REFRESH_DIV`-1.
  - On wrap, the digit index advances 0→1→2→3→4→0.
  - Exactly one `an` bit is low: the current index.
- Decode (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. A blank digit is 1111111.
- Blanking: with `BLANK_LEADING`=1, digit i>0 is blanked when digits i..4 are all zero. Digit 0 is never blanked.
- Display digit registers change only in LATCH, so the display never shows a partial conversion.

## Timing
- Reset values:
  - Outputs: `seg`=7'h7F, `an`=5'h1F, `busy`=0.
  - Internal: state=IDLE, `pending`=0, `ready_q`=0, all digit registers 0, refresh counter 0, index 0.
- `an` and `seg` are registered. After reset release, the first digit (index 0, showing "0") is lit on the first clock edge. Each digit then stays lit for `REFRESH_DIV` cycles.
- Latency: when the request is sampled at edge k, SHIFT occupies edges k+1..k+16 and the digits update at edge k+17.
- `busy` is 1 from after edge k to after edge k+17. It stays high continuously when a pending reload happens.
- `READY` held high does not retrigger a conversion. A new rising edge is required.
- If `n_reset` is asserted mid-conversion, all state returns to reset values immediately and the partial result is discarded.

## Structure
- Package `display_pkg` holds:
  - the state enum {IDLE, SHIFT, LATCH};
  - `NUM_DIGITS`=5;
  - the seven-segment constants for 0–9 and blank.
- Sub-module `bin2bcd` holds the sequential converter:
  - inputs `start`, `bin[15:0]`;
  - outputs `bcd[19:0]` and a one-cycle `done` pulse.
- The top level holds edge detection, `pending`, the digit registers, the scan counter and the decode.

## Test plan
- Reset, then hold `n_reset` high with no `READY` edge → `seg`=7F and `an`=1F during reset. After release, `an`=11110 and `seg`=1000000. All other digits are blank.
- `AQ`=16'h0F11 with a `READY` rising edge → digits update 17 cycles later to 3857. The scan shows 7,5,8,3 on `an[0..3]`; `an[4]` digit is blank.
- `AQ`=16'hFFFF → 65535, all five digits lit, `an[4]` showing 6 (0000010).
- `AQ`=16'h0000 → only digit 0 shows 0; digits 1–4 show 1111111.
- Second `READY` edge 5 cycles into a conversion → `busy` stays high through the reload. The final digits match the second `AQ` at edge k+35.
- `n_reset` pulsed low at SHIFT iteration 8 → `busy`=0, digits 0, no LATCH. A later `READY` edge converts correctly.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the result display.
//   state_t     - converter FSM states
//   NUM_DIGITS  - number of BCD / seven-segment digits
//   SEG_*       - active-low segment patterns {g,f,e,d,c,b,a}
//   seg_decode  - BCD digit to segment pattern
package display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int NUM_DIGITS = 5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: sequential double-dabble converter, one bit per clock.
//   clk, n_reset - clock, async active-low reset
//   start        - load bin and begin (accepted in IDLE and LATCH)
//   bin[15:0]    - binary value to convert
//   bcd[19:0]    - five BCD digits, valid while done is high
//   done         - one-cycle pulse in LATCH, after the 16th shift
//   busy         - converter not idle
module bin2bcd
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        done,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d, adj;
    logic [3:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, LATCH: begin
                if (start) begin
                    state_d = SHIFT;
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Top adjusted bit is always 0 (result <= 65535), so it is dropped.
                {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = LATCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bcd  = bcd_q;
    assign done = (state_q == LATCH);
    assign busy = (state_q != IDLE);

endmodule

// File: rtl/result_display.sv
// result_display: captures the multiplier product on each READY rising edge,
// converts it to BCD and scans it onto a 5-digit common-anode display.
//   clk, n_reset - clock, async active-low reset
//   AQ[15:0]     - product, stable while READY is high
//   READY        - rising edge requests a conversion
//   seg[6:0]     - segments {g,f,e,d,c,b,a}, active-low, registered
//   an[4:0]      - digit enables, active-low, an[0] = units, registered
//   busy         - conversion in progress
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV   = 3330,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [15:0]           AQ,
    input  logic                  READY,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic                         ready_q, req, start, pending_q, done;
    logic [19:0]                  bcd;
    logic [NUM_DIGITS-1:0][3:0]   digit_q;
    logic [NUM_DIGITS-1:0]        blank;
    logic                         all_zero;
    logic [CW-1:0]                cnt_q;
    logic [2:0]                   idx_q;
    logic [3:0]                   cur_digit;

    assign req = READY & ~ready_q;
    // A request seen during LATCH is folded into the reload, same as pending.
    assign start = busy ? (done & (pending_q | req)) : req;

    bin2bcd u_conv (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .bin     (AQ),
        .bcd     (bcd),
        .done    (done),
        .busy    (busy)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
            digit_q   <= '0;
        end else begin
            ready_q <= READY;
            if (done) begin
                digit_q   <= bcd;
                pending_q <= 1'b0;
            end else if (busy && req) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Digit i>0 is blank when it and every digit above it are zero.
    always_comb begin
        blank    = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero & (digit_q[i] == 4'd0);
            blank[i] = (BLANK_LEADING != 0) & all_zero;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx_q == 3'(i)) cur_digit = digit_q[i];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an    <= '1;
            seg   <= SEG_BLANK;
        end else begin
            if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            an  <= ~(NUM_DIGITS'(1) << idx_q);
            seg <= blank[idx_q] ? SEG_BLANK : seg_decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] AQ;
    logic        READY;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        busy;

    int checks = 0;
    int errors = 0;

    result_display #(.REFRESH_DIV(D), .BLANK_LEADING(1)) dut (
        .clk(clk), .n_reset(n_reset), .AQ(AQ), .READY(READY),
        .seg(seg), .an(an), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until digit i is lit, then compare its segments.
    task automatic digit_is(input string tag, input int i, input logic [6:0] exp_seg);
        logic [4:0] exp_an;
        int n;
        exp_an = 5'b11111 ^ (5'b00001 << i);
        n = 0;
        while (an !== exp_an && n < 6*D) begin
            tick();
            n++;
        end
        chk({tag, "_an"}, 32'(an), 32'(exp_an));
        chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    task automatic convert(input logic [15:0] v);
        AQ = v;
        READY = 1'b1;
        tick();
        READY = 1'b0;
        repeat (19) tick();
    endtask

    logic ok;

    initial begin
        n_reset = 1'b0;
        READY = 1'b0;
        AQ = 16'h0000;
        repeat (3) tick();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'h1F);
        chk("rst_busy", 32'(busy), 32'h0);

        n_reset = 1'b1;
        tick();
        chk("first_an", 32'(an), 32'h1E);
        chk("first_seg", 32'(seg), 32'h40);
        digit_is("init_d1", 1, 7'h7F);
        digit_is("init_d4", 4, 7'h7F);

        // 0x0F11 = 3857, with busy timing around edge k
        AQ = 16'h0F11;
        READY = 1'b1;
        tick();
        chk("busy_k", 32'(busy), 32'h1);
        repeat (16) tick();
        chk("busy_k16", 32'(busy), 32'h1);
        tick();
        chk("busy_k17", 32'(busy), 32'h0);
        repeat (2) tick();
        digit_is("h0f11_d0", 0, 7'h78);
        digit_is("h0f11_d1", 1, 7'h12);
        digit_is("h0f11_d2", 2, 7'h00);
        digit_is("h0f11_d3", 3, 7'h30);
        digit_is("h0f11_d4", 4, 7'h7F);

        // READY still high: no retrigger
        repeat (3) tick();
        chk("hold_ready", 32'(busy), 32'h0);
        READY = 1'b0;
        tick();

        convert(16'hFFFF);
        digit_is("hffff_d0", 0, 7'h12);
        digit_is("hffff_d1", 1, 7'h30);
        digit_is("hffff_d2", 2, 7'h12);
        digit_is("hffff_d3", 3, 7'h12);
        digit_is("hffff_d4", 4, 7'h02);

        convert(16'h0000);
        digit_is("zero_d0", 0, 7'h40);
        digit_is("zero_d1", 1, 7'h7F);
        digit_is("zero_d3", 3, 7'h7F);
        digit_is("zero_d4", 4, 7'h7F);

        // Second request 5 cycles into a conversion of 1234; reload takes 42
        AQ = 16'd1234;
        READY = 1'b1;
        tick();                         // edge k
        READY = 1'b0;
        repeat (4) tick();
        AQ = 16'd42;
        READY = 1'b1;
        tick();                         // edge k+5
        READY = 1'b0;
        ok = 1'b1;
        repeat (28) begin               // edges k+6..k+33
            tick();
            ok = ok & (busy === 1'b1);
        end
        chk("pend_busy_hold", 32'(ok), 32'h1);
        repeat (2) tick();              // edge k+35
        chk("pend_busy_k35", 32'(busy), 32'h0);
        repeat (2) tick();
        digit_is("pend_d0", 0, 7'h24);
        digit_is("pend_d1", 1, 7'h19);
        digit_is("pend_d2", 2, 7'h7F);

        // Reset in the middle of SHIFT
        AQ = 16'h0F11;
        READY = 1'b1;
        tick();                         // edge k
        READY = 1'b0;
        repeat (8) tick();
        n_reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_an", 32'(an), 32'h1F);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        tick();
        n_reset = 1'b1;
        tick();
        chk("post_rst_an", 32'(an), 32'h1E);
        chk("post_rst_seg", 32'(seg), 32'h40);
        repeat (20) tick();
        chk("post_rst_idle", 32'(busy), 32'h0);
        digit_is("post_rst_d1", 1, 7'h7F);

        convert(16'h0F11);
        digit_is("reconv_d0", 0, 7'h78);
        digit_is("reconv_d3", 3, 7'h30);
        digit_is("reconv_d4", 4, 7'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
